seq_alu: RTL and testbench

Parametrised, handshaked ALU that extends the datapath op set with iterative multiply and divide. Single-cycle logic/shift/add ops complete in one cycle. MUL/MULHU/DIVU/REMU run on a bit-serial engine for N cycles. Sits between operand fetch and writeback so multi-cycle ops stall the pipeline through `in_ready`/`out_valid` rather than stretching the clock.

---
 rtl/seq_alu_pkg.sv | 33 +++
 rtl/seq_alu_if.sv | 29 ++
 rtl/muldiv_unit.sv | 90 +++++++++
 rtl/seq_alu.sv | 158 +++++++++++++++
 tb/tb_seq_alu.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Shared ALU op codes and small op-classification helpers.
// Every op-code user in the slice imports this package.
package seq_alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 4'h0,
    OP_OR    = 4'h1,
    OP_XOR   = 4'h2,
    OP_NOR   = 4'h3,
    OP_SLT   = 4'h4,
    OP_SLL   = 4'h5,
    OP_SRL   = 4'h6,
    OP_SRA   = 4'h7,
    OP_ADD   = 4'h8,
    OP_SUB   = 4'h9,
    OP_MUL   = 4'hA,
    OP_MULHU = 4'hB,
    OP_DIVU  = 4'hC,
    OP_REMU  = 4'hD
  } alu_op_e;

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // Ops whose result is the upper half of the engine accumulator.
  function automatic logic op_sel_hi(input logic [OP_W-1:0] op);
    return (op == OP_MULHU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between operand fetch, seq_alu and writeback.
interface seq_alu_if
  import seq_alu_pkg::*;
#(
  parameter int unsigned N = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    x;
  logic [N-1:0]    y;
  logic [OP_W-1:0] op_code;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    z;
  logic            equal;
  logic            zero;
  logic            overflow;
  logic            div_by_zero;

  modport slave (
    input  in_valid, x, y, op_code, out_ready,
    output in_ready, out_valid, z, equal, zero, overflow, div_by_zero
  );

  modport master (
    output in_valid, x, y, op_code, out_ready,
    input  in_ready, out_valid, z, equal, zero, overflow, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Bit-serial engine: shift-add multiply and restoring divide over a 2N-bit
// accumulator, one bit per cycle for exactly N cycles after start.
module muldiv_unit
  import seq_alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  output logic            done,
  output logic [N-1:0]    result,
  output logic            hi_nonzero
);
  localparam int unsigned CNT_W = $clog2(N) + 1;

  logic [2*N-1:0]   acc_q, acc_d;
  logic [N-1:0]     opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             div_q, div_d;
  logic             hi_q, hi_d;

  logic [N:0] add_sum;
  logic [N:0] rem_shift;
  logic [N:0] rem_sub;

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    div_d  = div_q;
    hi_d   = hi_q;
    done   = 1'b0;

    add_sum   = {1'b0, acc_q[2*N-1:N]} + {1'b0, opnd_q};
    rem_shift = acc_q[2*N-1:N-1];
    rem_sub   = rem_shift - {1'b0, opnd_q};

    if (start) begin
      acc_d  = {{N{1'b0}}, a};
      opnd_d = b;
      cnt_d  = CNT_W'(N - 1);
      busy_d = 1'b1;
      div_d  = op_is_div(op);
      hi_d   = op_sel_hi(op);
    end else if (busy_q) begin
      // Divide: hi = partial remainder, lo = dividend shifting out / quotient shifting in.
      if (div_q) begin
        if (!rem_sub[N]) acc_d = {rem_sub[N-1:0], acc_q[N-2:0], 1'b1};
        else             acc_d = {rem_shift[N-1:0], acc_q[N-2:0], 1'b0};
      end else begin
        acc_d = acc_q[0] ? {add_sum, acc_q[N-1:1]} : {1'b0, acc_q[2*N-1:1]};
      end
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    // Taken from the next-state value so the final step is visible in the done cycle.
    result     = hi_q ? acc_d[2*N-1:N] : acc_d[N-1:0];
    hi_nonzero = |acc_d[2*N-1:N];
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      hi_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      div_q  <= div_d;
      hi_q   <= hi_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/shift/add ops plus iterative MUL/MULHU/DIVU/REMU.
// Results and flags are registered on entry to DONE and held until out_ready.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic      clk,
  input  logic      rstb,
  seq_alu_if.slave  bus
);
  localparam int unsigned SH_W = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [N-1:0]    z_q, z_d;
  logic            equal_q, equal_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;
  logic            dbz_q, dbz_d;

  logic [SH_W-1:0] shamt;
  logic [N-1:0]    sum, diff;
  logic [N-1:0]    sc_res;
  logic            sc_ovf, sc_dbz, sc_undef, md_go;
  logic            md_start, md_done, md_hi_nonzero;
  logic [N-1:0]    md_result;

  assign shamt = bus.x[SH_W-1:0];
  assign sum   = bus.x + bus.y;
  assign diff  = bus.x - bus.y;

  always_comb begin
    sc_res   = '0;
    sc_ovf   = 1'b0;
    sc_dbz   = 1'b0;
    sc_undef = 1'b0;
    md_go    = 1'b0;
    case (alu_op_e'(bus.op_code))
      OP_AND:  sc_res = bus.x & bus.y;
      OP_OR:   sc_res = bus.x | bus.y;
      OP_XOR:  sc_res = bus.x ^ bus.y;
      OP_NOR:  sc_res = ~(bus.x | bus.y);
      OP_SLT:  sc_res = {{(N-1){1'b0}}, $signed(bus.x) < $signed(bus.y)};
      OP_SLL:  sc_res = bus.y << shamt;
      OP_SRL:  sc_res = bus.y >> shamt;
      OP_SRA:  sc_res = $signed(bus.y) >>> shamt;
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (bus.x[N-1] == bus.y[N-1]) && (sum[N-1] != bus.x[N-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (bus.x[N-1] != bus.y[N-1]) && (diff[N-1] != bus.x[N-1]);
      end
      OP_MUL, OP_MULHU: md_go = 1'b1;
      // Divide by zero resolves here without starting the engine.
      OP_DIVU: begin
        md_go  = (bus.y != '0);
        sc_res = '1;
        sc_dbz = 1'b1;
      end
      OP_REMU: begin
        md_go  = (bus.y != '0);
        sc_res = bus.x;
        sc_dbz = 1'b1;
      end
      default: sc_undef = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    z_d      = z_q;
    equal_d  = equal_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    md_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.op_code;
          equal_d = !sc_undef && (bus.x == bus.y);
          if (md_go) begin
            md_start = 1'b1;
            state_d  = S_BUSY;
          end else begin
            state_d = S_DONE;
            z_d     = sc_res;
            zero_d  = !sc_undef && (sc_res == '0);
            ovf_d   = sc_ovf;
            dbz_d   = sc_dbz;
          end
        end
      end
      S_BUSY: begin
        if (md_done) begin
          state_d = S_DONE;
          z_d     = md_result;
          zero_d  = (md_result == '0);
          ovf_d   = (op_q == OP_MUL) && md_hi_nonzero;
          dbz_d   = 1'b0;
        end
      end
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      z_q     <= '0;
      equal_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      z_q     <= z_d;
      equal_q <= equal_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  muldiv_unit #(.N(N)) u_muldiv_unit (
    .clk        (clk),
    .rstb       (rstb),
    .start      (md_start),
    .op         (bus.op_code),
    .a          (bus.x),
    .b          (bus.y),
    .done       (md_done),
    .result     (md_result),
    .hi_nonzero (md_hi_nonzero)
  );

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.z           = z_q;
  assign bus.equal       = equal_q;
  assign bus.zero        = zero_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (N=32): directed ops push expected results,
// a negedge monitor pops and compares on each new out_valid.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int unsigned N = 32;

  typedef struct {
    string       name;
    logic [31:0] z;
    logic        eq;
    logic        zr;
    logic        ov;
    logic        dz;
    int unsigned lat;
    longint      acc;
  } exp_t;

  logic   clk;
  logic   rstb;
  longint cyc;
  int     checks;
  int     failures;
  logic   ov_prev;
  exp_t   sb[$];

  seq_alu_if #(.N(N)) bus ();

  seq_alu #(.N(N)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a rising out_valid is a new result; compare against the oldest expectation.
  initial ov_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rstb && bus.out_valid && !ov_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_z"},   64'(bus.z),           64'(e.z));
        chk({e.name, "_eq"},  64'(bus.equal),       64'(e.eq));
        chk({e.name, "_zr"},  64'(bus.zero),        64'(e.zr));
        chk({e.name, "_ov"},  64'(bus.overflow),    64'(e.ov));
        chk({e.name, "_dz"},  64'(bus.div_by_zero), 64'(e.dz));
        chk({e.name, "_lat"}, 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
    ov_prev = bus.out_valid;
  end

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic issue(input string name, input logic [3:0] op,
                       input logic [31:0] xv, input logic [31:0] yv,
                       input logic [31:0] ez, input logic eeq, input logic ezr,
                       input logic eov, input logic edz, input int unsigned elat);
    exp_t e;
    @(negedge clk);
    chk({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.op_code  = op;
    bus.x        = xv;
    bus.y        = yv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    e.name = name; e.z = ez; e.eq = eeq; e.zr = ezr; e.ov = eov; e.dz = edz;
    e.lat = elat; e.acc = cyc;
    sb.push_back(e);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rstb          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.x         = '0;
    bus.y         = '0;
    bus.op_code   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(bus.in_ready),    64'd1);
    chk("rst_out_valid", 64'(bus.out_valid),   64'd0);
    chk("rst_z",         64'(bus.z),           64'd0);
    chk("rst_flags",     64'({bus.equal, bus.zero, bus.overflow, bus.div_by_zero}), 64'd0);
    @(negedge clk);
    rstb = 1'b1;

    //     name          op        x             y             z             eq zr ov dz lat
    issue("add_ovf",    OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 0, 1);
    issue("sub_ovf",    OP_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 0, 1, 0, 1);
    issue("add_eq",     OP_ADD,   32'd5,        32'd5,        32'd10,       1, 0, 0, 0, 1);
    issue("sub_zero",   OP_SUB,   32'd5,        32'd5,        32'd0,        1, 1, 0, 0, 1);
    issue("mul_lo",     OP_MUL,   32'h00010000, 32'h00010000, 32'h00000000, 1, 1, 1, 0, 33);
    issue("mulhu",      OP_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, 1, 0, 0, 0, 33);
    issue("mul_ff",     OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1, 0, 1, 0, 33);
    issue("mulhu_ff",   OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 0, 0, 0, 33);
    issue("divu",       OP_DIVU,  32'd100,      32'd7,        32'd14,       0, 0, 0, 0, 33);
    issue("remu",       OP_REMU,  32'd100,      32'd7,        32'd2,        0, 0, 0, 0, 33);
    issue("divu_small", OP_DIVU,  32'd7,        32'd100,      32'd0,        0, 1, 0, 0, 33);
    issue("remu_small", OP_REMU,  32'd7,        32'd100,      32'd7,        0, 0, 0, 0, 33);
    issue("divu_max",   OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 0, 0, 0, 0, 33);
    issue("divu_by0",   OP_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, 0, 0, 0, 1, 1);
    issue("remu_by0",   OP_REMU,  32'd5,        32'd0,        32'd5,        0, 0, 0, 1, 1);
    issue("sra",        OP_SRA,   32'd4,        32'h80000000, 32'hF8000000, 0, 0, 0, 0, 1);
    issue("srl",        OP_SRL,   32'd4,        32'h80000000, 32'h08000000, 0, 0, 0, 0, 1);
    issue("sll_mask",   OP_SLL,   32'd33,       32'd1,        32'd2,        0, 0, 0, 0, 1);
    issue("slt",        OP_SLT,   32'hFFFFFFFF, 32'd1,        32'd1,        0, 0, 0, 0, 1);
    issue("and",        OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 0, 1);
    issue("or",         OP_OR,    32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0, 0, 1);
    issue("xor",        OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0, 0, 1);
    issue("nor",        OP_NOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 0, 0, 0, 0, 1);
    issue("undef",      4'hF,     32'd3,        32'd3,        32'd0,        0, 0, 0, 0, 1);

    // Backpressure: result held in DONE; a concurrent op must be ignored.
    bus.out_ready = 1'b0;
    issue("bp_add", OP_ADD, 32'd1, 32'd2, 32'd3, 0, 0, 0, 0, 1);
    bus.op_code  = OP_SUB;
    bus.x        = 32'd9;
    bus.y        = 32'd1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
      chk("bp_z",         64'(bus.z),         64'd3);
      chk("bp_flags",     64'({bus.equal, bus.zero, bus.overflow, bus.div_by_zero}), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_release_in_ready",  64'(bus.in_ready),  64'd1);
    repeat (40) @(negedge clk);

    // Reset ten cycles into a DIVU: op dropped, no result ever appears.
    bus.op_code  = OP_DIVU;
    bus.x        = 32'd100;
    bus.y        = 32'd7;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid_busy_in_ready", 64'(bus.in_ready), 64'd0);
    rstb = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("mrst_z",         64'(bus.z),         64'd0);
    chk("mrst_flags",     64'({bus.equal, bus.zero, bus.overflow, bus.div_by_zero}), 64'd0);
    @(negedge clk);
    rstb = 1'b1;
    repeat (40) @(negedge clk);
    issue("post_rst_add", OP_ADD, 32'd3, 32'd4, 32'd7, 0, 0, 0, 0, 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
